// File: rtl/map_ram_arbiter_pkg.sv
// Shared definitions for the map RAM and the blocks that access it.
package map_ram_arbiter_pkg;

  // Map RAM geometry: 16x16 grid of 4-bit cell codes
  localparam int unsigned MAP_ADDR_W   = 8;
  localparam int unsigned MAP_DATA_W   = 4;

  // Arbiter sizing; the picker is a fixed 3-way design
  localparam int unsigned MAP_N_REQ    = 3;
  localparam int unsigned MAP_LOCK_MAX = 16;

  // Requester identities (bit position in req/gnt/rvalid)
  typedef enum logic [1:0] {
    REQ_SNAKE = 2'd0,
    REQ_FOOD  = 2'd1,
    REQ_DISP  = 2'd2
  } req_id_t;

  // Cell codes stored in the map RAM
  typedef enum logic [3:0] {
    CELL_EMPTY = 4'h0,
    CELL_BODY  = 4'h1,
    CELL_FOOD  = 4'h2,
    CELL_WALL  = 4'h3
  } cell_t;

  // Ownership state of the arbiter
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  // Next requester index in round-robin order, wrapping 2 -> 0
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/map_ram_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first eligible requester at or after ptr.
module rr_pick3
  import map_ram_arbiter_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  // Search order ptr, ptr+1, ptr+2 (mod 3); winner is don't-care when nothing is eligible
  always_comb begin
    valid  = |eligible;
    winner = REQ_SNAKE;
    case (ptr)
      2'd1: begin
        if (eligible[1])      winner = REQ_FOOD;
        else if (eligible[2]) winner = REQ_DISP;
        else                  winner = REQ_SNAKE;
      end
      2'd2: begin
        if (eligible[2])      winner = REQ_DISP;
        else if (eligible[0]) winner = REQ_SNAKE;
        else                  winner = REQ_FOOD;
      end
      default: begin
        if (eligible[0])      winner = REQ_SNAKE;
        else if (eligible[1]) winner = REQ_FOOD;
        else                  winner = REQ_DISP;
      end
    endcase
  end

endmodule

// File: rtl/map_ram_arbiter.sv
// Round-robin arbiter sharing the single-port map RAM between snake mover,
// food generator and VGA renderer, with an optional ownership lock for
// read-modify-write sequences and a timeout that force-releases a stale lock.
module map_ram_arbiter
  import map_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = MAP_ADDR_W,
  parameter int unsigned DATA_W   = MAP_DATA_W,
  parameter int unsigned N_REQ    = MAP_N_REQ,
  parameter int unsigned LOCK_MAX = MAP_LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_re,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      lock_err
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  // Lock FSM state
  lock_state_t          r_state;
  logic [1:0]           r_owner;
  logic [CNT_W-1:0]     r_lock_cnt;
  logic                 r_lock_err;

  // Issue pipeline state
  logic [1:0]           r_ptr;
  logic [N_REQ-1:0]     r_gnt;
  logic [N_REQ-1:0]     r_rvalid;
  logic [ADDR_W-1:0]    r_ram_addr;
  logic [DATA_W-1:0]    r_ram_wdata;
  logic                 r_ram_re;
  logic                 r_ram_we;

  // Combinational decisions
  lock_state_t          w_nxt_state;
  logic [1:0]           w_nxt_owner;
  logic [CNT_W-1:0]     w_nxt_cnt;
  logic                 w_nxt_err;
  logic [N_REQ-1:0]     w_owner_mask;
  logic [N_REQ-1:0]     w_eligible;
  logic                 w_pick_valid;
  logic [1:0]           w_pick_winner;
  logic [N_REQ-1:0]     w_win_oh;
  logic                 w_win_we;
  logic                 w_win_lock;
  logic                 w_timeout;
  logic                 w_issue;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;

  // A requester granted last cycle still shows its stale req; mask it. While locked only the owner may win.
  assign w_owner_mask = N_REQ'(1) << r_owner;
  assign w_eligible   = req & ~r_gnt & ((r_state == ST_LOCKED) ? w_owner_mask : {N_REQ{1'b1}});

  rr_pick3 u_pick (
    .eligible (w_eligible),
    .ptr      (r_ptr),
    .valid    (w_pick_valid),
    .winner   (w_pick_winner)
  );

  // The timeout cycle releases the lock and issues nothing
  assign w_timeout  = (r_state == ST_LOCKED) && (r_lock_cnt == CNT_W'(LOCK_MAX));
  assign w_issue    = w_pick_valid && !w_timeout;
  assign w_win_oh   = N_REQ'(1) << w_pick_winner;
  assign w_win_we   = |(req_we & w_win_oh);
  assign w_win_lock = |(req_lock & w_win_oh);

  // Select the winning requester's address and write data
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Lock FSM next state: take/keep/release ownership and run the stale-lock counter
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_cnt   = r_lock_cnt;
    w_nxt_err   = r_lock_err;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_issue && w_win_lock) begin
          w_nxt_state = ST_LOCKED;
          w_nxt_owner = w_pick_winner;
          w_nxt_cnt   = '0;
        end
      end
      ST_LOCKED: begin
        if (w_timeout) begin
          w_nxt_state = ST_UNLOCKED;
          w_nxt_cnt   = '0;
          w_nxt_err   = 1'b1;
        end else if (w_issue) begin
          w_nxt_cnt = '0;
          if (!w_win_lock) begin
            w_nxt_state = ST_UNLOCKED;
          end
        end else begin
          w_nxt_cnt = r_lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = ST_UNLOCKED;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOCKED;
      r_owner    <= 2'd0;
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_owner    <= w_nxt_owner;
      r_lock_cnt <= w_nxt_cnt;
      r_lock_err <= w_nxt_err;
    end
  end

  // Issue stage: drive the RAM, pulse gnt, advance the rr pointer; rvalid follows a read by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 2'd0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
    end else begin
      r_gnt    <= w_issue ? w_win_oh : '0;
      r_ram_re <= w_issue & ~w_win_we;
      r_ram_we <= w_issue & w_win_we;
      r_rvalid <= r_ram_re ? r_gnt : '0;
      if (w_issue) begin
        r_ram_addr  <= w_addr;
        r_ram_wdata <= w_wdata;
        r_ptr       <= rr_next(w_pick_winner);
      end
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_re    = r_ram_re;
  assign ram_we    = r_ram_we;
  assign lock_err  = r_lock_err;
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: RAM model, cycle-level reference model checked every
// cycle, directed table of single accesses, and hand sequences for contention,
// lock RMW, lock timeout and mid-read reset, followed by random traffic.
module tb_map_ram_arbiter;

  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, req_we, req_lock;
  logic [23:0] req_addr;
  logic [11:0] req_wdata;
  logic [2:0]  gnt, rvalid;
  logic [3:0]  rdata;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_wdata;
  logic        ram_re, ram_we;
  logic [3:0]  ram_rdata;
  logic        lock_err;

  int n_checks = 0;
  int n_fail   = 0;

  map_ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] init_cell(input int a);
    return (a == 8'h2A) ? 4'hE : 4'(a);
  endfunction

  // Single-port RAM model: write or read on the edge, read data one cycle later
  logic [3:0] mem [256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = init_cell(i);
      mem_init = 1'b1;
    end
    if (ram_we) mem[ram_addr] = ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // Reference model: arbitration rules applied once per cycle; e_* are the outputs expected now
  logic [3:0] shadow [256];
  bit         shadow_init = 1'b0;
  int         m_ptr, m_owner, m_idle;
  bit         m_locked, m_err;
  logic [2:0] e_gnt, e_rvalid;
  logic       e_re, e_we;
  logic [7:0] e_addr;
  logic [3:0] e_wdata, e_rdata, pend_rdata;

  always @(negedge clk) begin : monitor
    int         win;
    bit         tmo;
    logic [2:0] elig, n_rvalid;
    logic [3:0] n_rdata;
    if (!shadow_init) begin
      for (int i = 0; i < 256; i++) shadow[i] = init_cell(i);
      shadow_init = 1'b1;
    end
    if (!rst_n) begin
      m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 0; m_err = 0;
      e_gnt = '0; e_rvalid = '0; e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_rdata = '0; pend_rdata = '0;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_ram_re_we", {30'd0, ram_re, ram_we}, 0);
      check("rst_ram_addr_wdata", {20'd0, ram_addr, ram_wdata}, 0);
      check("rst_lock_err", 32'(lock_err), 0);
    end else begin
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("rvalid", 32'(rvalid), 32'(e_rvalid));
      check("ram_re", 32'(ram_re), 32'(e_re));
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      check("lock_err", 32'(lock_err), 32'(m_err));
      if (e_rvalid != 0) check("rdata", 32'(rdata), 32'(e_rdata));
      // write presented now lands at the coming edge, before any read issued there
      if (e_we) shadow[e_addr] = e_wdata;
      n_rvalid = e_re ? e_gnt : 3'b000;
      n_rdata  = pend_rdata;
      for (int i = 0; i < 3; i++)
        elig[i] = req[i] && !e_gnt[i] && (!m_locked || m_owner == i);
      tmo = m_locked && (m_idle >= LOCK_MAX);
      win = -1;
      if (!tmo)
        for (int k = 0; k < 3; k++)
          if (win < 0 && elig[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
      if (tmo) begin
        m_locked = 0; m_err = 1; m_idle = 0;
      end else if (win >= 0) begin
        m_ptr = (win + 1) % 3; m_locked = req_lock[win]; m_owner = win; m_idle = 0;
      end else if (m_locked) begin
        m_idle++;
      end
      if (win >= 0) begin
        e_gnt   = 3'(1 << win);
        e_re    = !req_we[win];
        e_we    = req_we[win];
        e_addr  = req_addr[win*8 +: 8];
        e_wdata = req_wdata[win*4 +: 4];
        if (!req_we[win]) pend_rdata = shadow[req_addr[win*8 +: 8]];
      end else begin
        e_gnt = '0; e_re = 0; e_we = 0;
      end
      e_rvalid = n_rvalid;
      e_rdata  = n_rdata;
    end
  end

  typedef struct {
    int         id;
    bit         we;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rdata;
  } vec_t;

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 0; req = '0; req_we = '0; req_lock = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // One lone access: gnt on the second sampled cycle, RAM fields, then rvalid/rdata
  task automatic access(input int id, input bit we, input logic [7:0] addr,
                        input logic [3:0] wdata, input logic [3:0] exp_rd);
    int n;
    bit got;
    @(posedge clk); #1;
    req[id] = 1'b1; req_we[id] = we; req_lock[id] = 1'b0;
    req_addr[id*8 +: 8] = addr; req_wdata[id*4 +: 4] = wdata;
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (gnt[id]) got = 1;
    end
    check("acc_gnt_latency", n, 2);
    if (got) begin
      check("acc_ram_re", 32'(ram_re), 32'(!we));
      check("acc_ram_we", 32'(ram_we), 32'(we));
      check("acc_ram_addr", 32'(ram_addr), 32'(addr));
      if (we) check("acc_ram_wdata", 32'(ram_wdata), 32'(wdata));
    end
    @(posedge clk); #1 req[id] = 1'b0;
    @(negedge clk);
    if (!we) begin
      check("acc_rvalid", 32'(rvalid), 32'(1 << id));
      check("acc_rdata", 32'(rdata), 32'(exp_rd));
    end else begin
      check("acc_no_rvalid", 32'(rvalid), 0);
    end
  endtask

  task automatic test_mid_read_reset();
    int n;
    @(posedge clk); #1;
    req[1] = 1; req_we[1] = 0; req_addr[15:8] = 8'h2A;
    n = 0;
    while (!gnt[1] && n < 10) begin @(negedge clk); n++; end
    check("mrr_ram_re", 32'(ram_re), 1);
    #2 rst_n = 0; req = '0;
    #1;
    check("mrr_async_gnt", 32'(gnt), 0);
    check("mrr_async_re_we", {30'd0, ram_re, ram_we}, 0);
    check("mrr_async_addr", 32'(ram_addr), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("mrr_no_rvalid", 32'(rvalid), 0);
    end
  endtask

  task automatic test_contention();
    int got_w[$];
    int got_c[$];
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    reset_dut();
    @(posedge clk); #1;
    req = 3'b111; req_we = '0; req_lock = '0; req_addr = {8'h22, 8'h11, 8'h00};
    for (int c = 0; c < 20 && got_w.size() < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (gnt[i]) begin got_w.push_back(i); got_c.push_back(c); end
    end
    check("cont_count", got_w.size(), 6);
    for (int k = 0; k < got_w.size() && k < 6; k++) begin
      check("cont_order", got_w[k], exp_order[k]);
      if (k > 0) check("cont_consecutive", got_c[k] - got_c[k-1], 1);
    end
    @(posedge clk); #1 req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock_rmw();
    int seq[$];
    int food_g;
    bit sw;
    reset_dut();
    access(0, 1'b0, 8'h37, 4'h0, 4'h7);   // leaves the rr pointer at the food generator
    @(posedge clk); #1;
    req = 3'b111; req_we = '0; req_lock = 3'b010;
    req_addr = {8'h80, 8'h10, 8'h40}; req_wdata = '0;
    food_g = 0; sw = 0;
    for (int c = 0; c < 30 && seq.size() < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (gnt[i]) seq.push_back(i);
      if (gnt[1]) food_g++;
      @(posedge clk); #1;
      if (food_g == 1 && !sw) begin
        req_we[1] = 1; req_wdata[7:4] = 4'h3; req_lock[1] = 0; sw = 1;
      end else if (food_g == 2) begin
        req[1] = 0;
      end
    end
    req = '0;
    check("rmw_count", seq.size(), 3);
    if (seq.size() == 3) begin
      check("rmw_first", seq[0], 1);
      check("rmw_second", seq[1], 1);
      check("rmw_third", seq[2], 2);
    end
    repeat (3) @(negedge clk);
    check("rmw_ram_cell", 32'(mem[8'h10]), 32'h3);
    check("rmw_no_lock_err", 32'(lock_err), 0);
  endtask

  task automatic test_lock_timeout();
    int c1, c2, ce, snake_g;
    reset_dut();
    access(0, 1'b0, 8'h01, 4'h0, 4'h1);
    @(posedge clk); #1;
    req = 3'b110; req_we = '0; req_lock = 3'b010; req_addr = {8'h90, 8'h20, 8'h00};
    c1 = -1; c2 = -1; ce = -1; snake_g = 0;
    for (int c = 0; c < 60 && c2 < 0; c++) begin
      @(negedge clk);
      if (gnt[1] && c1 < 0) c1 = c;
      if (lock_err && ce < 0) ce = c;
      if (gnt[2]) c2 = c;
      if (gnt[0]) snake_g++;
      @(posedge clk); #1;
      if (c1 >= 0) req[1] = 0;
      if (c2 >= 0) req[2] = 0;
    end
    req = '0;
    check("tmo_lock_taken", 32'(c1 >= 0), 1);
    check("tmo_err_delay", ce - c1, LOCK_MAX + 1);
    check("tmo_next_grant_delay", c2 - c1, LOCK_MAX + 2);
    check("tmo_no_snake", snake_g, 0);
    check("tmo_err_sticky", 32'(lock_err), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic random_phase(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !gnt[i]) begin
          if ($urandom_range(15) == 0) req[i] = 0;
        end else if ($urandom_range(1) == 0) begin
          req[i]      = 1;
          req_we[i]   = 1'($urandom_range(1));
          req_lock[i] = ($urandom_range(7) == 0);
          req_addr[i*8 +: 8]  = $urandom_range(1) ? 8'($urandom_range(15)) : 8'($urandom);
          req_wdata[i*4 +: 4] = 4'($urandom);
        end else begin
          req[i] = 0;
        end
      end
    end
    @(posedge clk); #1 req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[8];
    vecs[0] = '{0, 1'b1, 8'h05, 4'h1, 4'h0};
    vecs[1] = '{2, 1'b0, 8'h05, 4'h0, 4'h1};
    vecs[2] = '{1, 1'b0, 8'h2A, 4'h0, 4'hE};
    vecs[3] = '{2, 1'b1, 8'hFF, 4'h9, 4'h0};
    vecs[4] = '{0, 1'b0, 8'hFF, 4'h0, 4'h9};
    vecs[5] = '{1, 1'b1, 8'h00, 4'h7, 4'h0};
    vecs[6] = '{1, 1'b0, 8'h00, 4'h0, 4'h7};
    vecs[7] = '{0, 1'b0, 8'h37, 4'h0, 4'h7};

    rst_n = 0; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(negedge clk);

    test_mid_read_reset();
    for (int v = 0; v < 8; v++)
      access(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
    test_contention();
    test_lock_rmw();
    test_lock_timeout();
    reset_dut();
    random_phase(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
